// File: rtl/regfile_wb_pkg.sv
// Shared pipeline definitions for the register file and write-back endpoint:
// default widths, the hard-wired zero register index and the sweep FSM states.
package regfile_wb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_wb_if.sv
// MEM/WB write-back inputs and ID-stage read ports of the register file.
// The pipeline side is the master and the register file is the slave.
interface regfile_wb_if
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              WB_MEMWB;
    logic [DATA_W-1:0] Data_MEMWB;
    logic [ADDR_W-1:0] rw_MEMWB;
    logic [ADDR_W-1:0] rs_ID;
    logic [ADDR_W-1:0] rt_ID;
    logic [DATA_W-1:0] busA_ID;
    logic [DATA_W-1:0] busB_ID;
    logic              Busy;

    modport master (
        output WB_MEMWB, Data_MEMWB, rw_MEMWB, rs_ID, rt_ID,
        input  busA_ID, busB_ID, Busy
    );

    modport slave (
        input  WB_MEMWB, Data_MEMWB, rw_MEMWB, rs_ID, rt_ID,
        output busA_ID, busB_ID, Busy
    );

endinterface

// File: rtl/regfile_wb_rdport.sv
// One combinational read port: forces register 0 and the clear sweep to zero,
// otherwise forwards a same-cycle write ahead of the stored value.
module regfile_rdport
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              run,
    input  logic [ADDR_W-1:0] idx,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = '0;
        if (run && (idx != ADDR_W'(ZERO_REG))) begin
            if (wr_en && (wr_idx == idx)) begin
                data = wr_data;
            end else begin
                data = stored;
            end
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Architectural register file with post-reset clear sweep, write-back commit,
// same-cycle read bypass and register 0 hard-wired to zero.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic         CLK,
    input logic         RST,
    regfile_wb_if.slave bus
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NREG];

    rf_state_t         state;
    rf_state_t         state_next;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_next;
    logic              run;
    logic              we;

    assign run      = (state == RUN);
    assign we       = run && bus.WB_MEMWB && (bus.rw_MEMWB != ADDR_W'(ZERO_REG));
    assign bus.Busy = (state == CLEAR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    // The index wraps back to 0 naturally on the last clear write.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        if (state == CLEAR) begin
            clr_idx_next = clr_idx + 1'b1;
            if (clr_idx == ADDR_W'(NREG - 1)) begin
                state_next = RUN;
            end
        end
    end

    // Storage has no reset of its own; the sweep is what zeroes it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (we) begin
                mem[bus.rw_MEMWB] <= bus.Data_MEMWB;
            end
        end
    end

    regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .run     (run),
        .idx     (bus.rs_ID),
        .wr_en   (we),
        .wr_idx  (bus.rw_MEMWB),
        .wr_data (bus.Data_MEMWB),
        .stored  (mem[bus.rs_ID]),
        .data    (bus.busA_ID)
    );

    regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .run     (run),
        .idx     (bus.rt_ID),
        .wr_en   (we),
        .wr_idx  (bus.rw_MEMWB),
        .wr_data (bus.Data_MEMWB),
        .stored  (mem[bus.rt_ID]),
        .data    (bus.busB_ID)
    );

endmodule

// File: tb/tb_regfile_wb.sv
// Directed testbench for regfile_wb: clear sweep timing, bypass, register 0,
// dropped writes during the sweep and reset in the middle of normal operation.
module tb_regfile_wb;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    regfile_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge, like the MEM/WB register feeding us.
    task automatic drive(input logic wb, input logic [4:0] rw, input logic [31:0] data,
                         input logic [4:0] rs, input logic [4:0] rt);
        bus.WB_MEMWB   = wb;
        bus.rw_MEMWB   = rw;
        bus.Data_MEMWB = data;
        bus.rs_ID      = rs;
        bus.rt_ID      = rt;
    endtask

    // Releases reset and walks the 32 clear cycles, planting a write at cycle 10
    // and on the final clear cycle, then a write on the first RUN cycle.
    task automatic test_sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            if (i == 9)       drive(1'b1, 5'd3, 32'h0000_00AA, 5'd3, 5'd3);
            else if (i == 31) drive(1'b1, 5'd12, 32'h0000_0077, 5'd12, 5'd0);
            else              drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
            #1;
            total++;
            if (bus.Busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL %s busy_cycle%0d: got %b want 1", tag, i, bus.Busy);
            end
            if (i == 9) begin
                total++;
                if (bus.busA_ID !== 32'h0) begin
                    bad++;
                    $display("[TB] FAIL %s clear_bus_zero: got %h want 00000000", tag, bus.busA_ID);
                end
            end
        end
        @(negedge clk);
        drive(1'b1, 5'd13, 32'h0000_0088, 5'd13, 5'd12);
        #1;
        total++;
        if (bus.Busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s busy_end: got %b want 0", tag, bus.Busy);
        end
        total++;
        if (bus.busA_ID !== 32'h0000_0088) begin
            bad++;
            $display("[TB] FAIL %s first_run_bypass: got %h want 00000088", tag, bus.busA_ID);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd13, 5'd12);
        #1;
        total++;
        if (bus.busA_ID !== 32'h0000_0088) begin
            bad++;
            $display("[TB] FAIL %s first_run_commit: got %h want 00000088", tag, bus.busA_ID);
        end
        total++;
        if (bus.busB_ID !== 32'h0) begin
            bad++;
            $display("[TB] FAIL %s last_clear_drop: got %h want 00000000", tag, bus.busB_ID);
        end
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        #1;
        total++;
        if (bus.busA_ID !== 32'h0) begin
            bad++;
            $display("[TB] FAIL %s clear_write_drop: got %h want 00000000", tag, bus.busA_ID);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (bus.Busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_busy: got %b want 1", bus.Busy);
        end
        total++;
        if (bus.busA_ID !== 32'h0 || bus.busB_ID !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_buses: got %h/%h want 0/0", bus.busA_ID, bus.busB_ID);
        end
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < 32; i++) begin
            if (i == 13) continue;
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            #1;
            total++;
            if (bus.busA_ID !== 32'h0) begin
                bad++;
                $display("[TB] FAIL zero_reg%0d: got %h want 00000000", i, bus.busA_ID);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
        #1;
        total++;
        if (bus.busA_ID !== 32'hDEAD_BEEF) begin
            bad++;
            $display("[TB] FAIL bypass_a: got %h want deadbeef", bus.busA_ID);
        end
        @(negedge clk);
        drive(1'b0, 5'd5, 32'h0, 5'd5, 5'd5);
        #1;
        total++;
        if (bus.busA_ID !== 32'hDEAD_BEEF || bus.busB_ID !== 32'hDEAD_BEEF) begin
            bad++;
            $display("[TB] FAIL stored_5: got %h/%h want deadbeef", bus.busA_ID, bus.busB_ID);
        end
        // A write to another register must not leak onto a port reading reg 5.
        @(negedge clk);
        drive(1'b1, 5'd6, 32'h1357_9BDF, 5'd5, 5'd6);
        #1;
        total++;
        if (bus.busA_ID !== 32'hDEAD_BEEF) begin
            bad++;
            $display("[TB] FAIL no_false_bypass: got %h want deadbeef", bus.busA_ID);
        end
        total++;
        if (bus.busB_ID !== 32'h1357_9BDF) begin
            bad++;
            $display("[TB] FAIL bypass_b: got %h want 13579bdf", bus.busB_ID);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        #1;
        total++;
        if (bus.busA_ID !== 32'h0 || bus.busB_ID !== 32'h0) begin
            bad++;
            $display("[TB] FAIL r0_bypass: got %h/%h want 0/0", bus.busA_ID, bus.busB_ID);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd6);
        #1;
        total++;
        if (bus.busA_ID !== 32'h0) begin
            bad++;
            $display("[TB] FAIL r0_stored: got %h want 00000000", bus.busA_ID);
        end
        total++;
        if (bus.busB_ID !== 32'h1357_9BDF) begin
            bad++;
            $display("[TB] FAIL stored_6: got %h want 13579bdf", bus.busB_ID);
        end
    endtask

    task automatic test_dual_bypass();
        @(negedge clk);
        drive(1'b1, 5'd9, 32'hCAFE_0001, 5'd9, 5'd9);
        #1;
        total++;
        if (bus.busA_ID !== 32'hCAFE_0001 || bus.busB_ID !== 32'hCAFE_0001) begin
            bad++;
            $display("[TB] FAIL dual_bypass: got %h/%h want cafe0001", bus.busA_ID, bus.busB_ID);
        end
        // Overwrite: bypass must beat the older stored value.
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h0BAD_F00D, 5'd9, 5'd9);
        #1;
        total++;
        if (bus.busA_ID !== 32'h0BAD_F00D || bus.busB_ID !== 32'h0BAD_F00D) begin
            bad++;
            $display("[TB] FAIL overwrite_bypass: got %h/%h want 0badf00d", bus.busA_ID, bus.busB_ID);
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h0000_0055, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
        #1;
        total++;
        if (bus.busA_ID !== 32'h0000_0055) begin
            bad++;
            $display("[TB] FAIL stored_7: got %h want 00000055", bus.busA_ID);
        end
        rst = 1'b1;
        test_sweep("rerun");
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
        #1;
        total++;
        if (bus.busA_ID !== 32'h0 || bus.busB_ID !== 32'h0) begin
            bad++;
            $display("[TB] FAIL cleared_7_5: got %h/%h want 0/0", bus.busA_ID, bus.busB_ID);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        test_reset();
        test_sweep("first");
        test_all_zero();
        test_bypass();
        test_zero_reg();
        test_dual_bypass();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
